// File: rtl/udp_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : udp_rx
// Purpose  : Parses an Ethernet/IPv4/UDP byte stream and forwards the payload
//            of frames addressed to this node with zero added latency.
// Revision : 1.0 - initial release
// ============================================================================
module udp_rx #(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
    parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678,
    parameter logic [15:0] LOCAL_DP  = 16'd8080
) (
    input  logic        logic_clk,
    input  logic        logic_rst_n,
    input  logic [7:0]  trans_rnet_data_in,
    input  logic        trans_rnet_valid_in,
    output logic        trans_rnet_ready_out,
    input  logic        trans_rnet_last_in,
    output logic [7:0]  udp_rdata_out,
    output logic        udp_rvalid_out,
    input  logic        udp_rready_in,
    output logic        udp_rlast_out,
    output logic [31:0] udp_rip_out,
    output logic [15:0] udp_rsp_out,
    output logic        udp_rerr_out
);

    localparam logic [2:0] c_ETH_HDR = 3'd0;
    localparam logic [2:0] c_IP_HDR  = 3'd1;
    localparam logic [2:0] c_UDP_HDR = 3'd2;
    localparam logic [2:0] c_PAYLOAD = 3'd3;
    localparam logic [2:0] c_DROP    = 3'd4;

    logic [2:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_mismatch;
    logic        r_mac_local_miss;
    logic        r_mac_bcast_miss;
    logic [31:0] r_src_ip;
    logic [15:0] r_src_port;
    logic [15:0] r_udp_len;
    logic [15:0] r_remain;
    logic [31:0] r_ip_out;
    logic [15:0] r_sp_out;
    logic        r_err;

    logic       w_fire;
    logic       w_hdr;
    logic       w_chk;
    logic       w_mac;
    logic [7:0] w_exp;
    logic [5:0] w_hdr_end;
    logic       w_to_eth;
    logic       w_final_mismatch;

    assign w_fire = trans_rnet_valid_in & trans_rnet_ready_out;
    assign w_hdr  = (r_state == c_ETH_HDR) | (r_state == c_IP_HDR) | (r_state == c_UDP_HDR);

    // Expected value of the current header byte and whether it is checked.
    always_comb begin
        w_chk     = 1'b0;
        w_mac     = 1'b0;
        w_exp     = 8'h00;
        w_hdr_end = 6'd0;
        case (r_state)
            c_ETH_HDR: begin
                w_hdr_end = 6'd13;
                if (r_cnt < 6'd6) begin
                    w_mac = 1'b1;
                    case (r_cnt[2:0])
                        3'd0:    w_exp = LOCAL_MAC[47:40];
                        3'd1:    w_exp = LOCAL_MAC[39:32];
                        3'd2:    w_exp = LOCAL_MAC[31:24];
                        3'd3:    w_exp = LOCAL_MAC[23:16];
                        3'd4:    w_exp = LOCAL_MAC[15:8];
                        default: w_exp = LOCAL_MAC[7:0];
                    endcase
                end else if (r_cnt == 6'd12) begin
                    w_chk = 1'b1;
                    w_exp = 8'h08;
                end else if (r_cnt == 6'd13) begin
                    w_chk = 1'b1;
                    w_exp = 8'h00;
                end
            end
            c_IP_HDR: begin
                w_hdr_end = 6'd19;
                if (r_cnt == 6'd0) begin
                    w_chk = 1'b1;
                    w_exp = 8'h45;
                end else if (r_cnt == 6'd9) begin
                    w_chk = 1'b1;
                    w_exp = 8'h11;
                end else if (r_cnt >= 6'd16) begin
                    w_chk = 1'b1;
                    case (r_cnt[1:0])
                        2'd0:    w_exp = LOCAL_IP[31:24];
                        2'd1:    w_exp = LOCAL_IP[23:16];
                        2'd2:    w_exp = LOCAL_IP[15:8];
                        default: w_exp = LOCAL_IP[7:0];
                    endcase
                end
            end
            c_UDP_HDR: begin
                w_hdr_end = 6'd7;
                if (r_cnt == 6'd2) begin
                    w_chk = 1'b1;
                    w_exp = LOCAL_DP[15:8];
                end else if (r_cnt == 6'd3) begin
                    w_chk = 1'b1;
                    w_exp = LOCAL_DP[7:0];
                end
            end
            default: ;
        endcase
    end

    // Any accepted last byte ends the frame, whatever state it lands in.
    assign w_to_eth = w_fire & trans_rnet_last_in &
                      (w_hdr | (r_state == c_PAYLOAD) | (r_state == c_DROP));
    assign w_final_mismatch = r_mismatch | (r_mac_local_miss & r_mac_bcast_miss);

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            r_state          <= c_ETH_HDR;
            r_cnt            <= 6'd0;
            r_mismatch       <= 1'b0;
            r_mac_local_miss <= 1'b0;
            r_mac_bcast_miss <= 1'b0;
            r_src_ip         <= 32'd0;
            r_src_port       <= 16'd0;
            r_udp_len        <= 16'd0;
            r_remain         <= 16'd0;
            r_ip_out         <= 32'd0;
            r_sp_out         <= 16'd0;
            r_err            <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_to_eth) begin
                r_state          <= c_ETH_HDR;
                r_cnt            <= 6'd0;
                r_mismatch       <= 1'b0;
                r_mac_local_miss <= 1'b0;
                r_mac_bcast_miss <= 1'b0;
                r_remain         <= 16'd0;
                if (w_hdr || (r_state == c_PAYLOAD && r_remain > 16'd1)) begin
                    r_err <= 1'b1;
                end
            end else if (w_fire) begin
                if (w_hdr) begin
                    if (w_chk && trans_rnet_data_in != w_exp) r_mismatch <= 1'b1;
                    if (w_mac && trans_rnet_data_in != w_exp) r_mac_local_miss <= 1'b1;
                    if (w_mac && trans_rnet_data_in != 8'hFF) r_mac_bcast_miss <= 1'b1;
                    if (r_state == c_IP_HDR && r_cnt >= 6'd12 && r_cnt <= 6'd15) begin
                        r_src_ip <= {r_src_ip[23:0], trans_rnet_data_in};
                    end
                    if (r_state == c_UDP_HDR && r_cnt <= 6'd1) begin
                        r_src_port <= {r_src_port[7:0], trans_rnet_data_in};
                    end
                    if (r_state == c_UDP_HDR && (r_cnt == 6'd4 || r_cnt == 6'd5)) begin
                        r_udp_len <= {r_udp_len[7:0], trans_rnet_data_in};
                    end
                    if (r_cnt == w_hdr_end) begin
                        r_cnt <= 6'd0;
                        if (r_state == c_ETH_HDR) begin
                            r_state <= c_IP_HDR;
                        end else if (r_state == c_IP_HDR) begin
                            r_state <= c_UDP_HDR;
                        end else begin
                            if (r_udp_len < 16'd8) r_err <= 1'b1;
                            if (w_final_mismatch || r_udp_len <= 16'd8) begin
                                r_state <= c_DROP;
                            end else begin
                                r_state  <= c_PAYLOAD;
                                r_remain <= r_udp_len - 16'd8;
                                r_ip_out <= r_src_ip;
                                r_sp_out <= r_src_port;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end else if (r_state == c_PAYLOAD) begin
                    r_remain <= r_remain - 16'd1;
                    if (r_remain == 16'd1) r_state <= c_DROP;
                end else if (r_state != c_DROP) begin
                    r_state <= c_ETH_HDR;
                    r_cnt   <= 6'd0;
                end
            end
        end
    end

    assign trans_rnet_ready_out = (r_state == c_PAYLOAD) ? udp_rready_in : 1'b1;
    assign udp_rvalid_out       = (r_state == c_PAYLOAD) & trans_rnet_valid_in;
    assign udp_rdata_out        = (r_state == c_PAYLOAD) ? trans_rnet_data_in : 8'h00;
    assign udp_rlast_out        = (r_state == c_PAYLOAD) & ((r_remain == 16'd1) | trans_rnet_last_in);
    assign udp_rip_out          = r_ip_out;
    assign udp_rsp_out          = r_sp_out;
    assign udp_rerr_out         = r_err;

endmodule
`default_nettype wire

// File: doc/udp_rx.md
UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 SHALL have parameter LOCAL_IP, default 32'hC0A8_006E, local IPv4 address accepted as destination.
REQ-002 SHALL have parameter LOCAL_MAC, default 48'hABCD_1234_5678, local MAC accepted as destination (48'hFFFF_FFFF_FFFF also accepted).
REQ-003 SHALL have parameter LOCAL_DP, default 16'd8080, accepted UDP destination port.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: logic_clk  in  1  clock; logic_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: trans_rnet_data_in  in  8  frame byte; trans_rnet_valid_in  in  1; trans_rnet_ready_out  out  1; trans_rnet_last_in  in  1  last frame byte.
REQ-006 SHALL have ports: udp_rdata_out  out  8  payload byte; udp_rvalid_out  out  1; udp_rready_in  in  1; udp_rlast_out  out  1  last payload byte.
REQ-007 SHALL have ports: udp_rip_out  out  32  source IP; udp_rsp_out  out  16  source port; udp_rerr_out  out  1  one-cycle malformed-frame pulse.

Function
REQ-008 Input frame SHALL be: 14-byte Ethernet header, 20-byte IPv4 header, 8-byte UDP header, payload, optional padding; no preamble, no FCS; fields big-endian.
REQ-009 A byte SHALL transfer on input when trans_rnet_valid_in and trans_rnet_ready_out are both high in the same cycle.
REQ-010 States SHALL be ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DROP; 6-bit header byte counter reset to 0 on each header-state entry.
REQ-011 trans_rnet_ready_out SHALL be 1 in ETH_HDR, IP_HDR, UDP_HDR, DROP; equal to udp_rready_in in PAYLOAD.
REQ-012 Header checks SHALL be byte-compared into a sticky mismatch flag: dst MAC = LOCAL_MAC or broadcast; ethertype 16'h0800; byte 0 of IP = 8'h45; protocol 8'h11; dst IP = LOCAL_IP; dst port = LOCAL_DP.
REQ-013 IP source address (IP bytes 12-15) SHALL be latched; UDP source port and UDP length SHALL be latched.
REQ-014 On the 8th UDP header byte: if mismatch or UDP length <= 8, go DROP; else go PAYLOAD with 16-bit remaining count = UDP length - 8.
REQ-015 UDP length < 8 SHALL additionally pulse udp_rerr_out; IP/UDP checksums SHALL NOT be checked.
REQ-016 In PAYLOAD, udp_rdata_out = trans_rnet_data_in and udp_rvalid_out = trans_rnet_valid_in, combinationally (zero latency); valid is 0 in every other state.
REQ-017 udp_rlast_out SHALL be high with the payload byte where remaining count = 1 or trans_rnet_last_in = 1.
REQ-018 Remaining count SHALL decrement per accepted payload byte; at the last payload byte: if trans_rnet_last_in, go ETH_HDR; else go DROP (padding discarded).
REQ-019 trans_rnet_last_in with remaining count > 1 (truncated payload) SHALL end output with udp_rlast_out, pulse udp_rerr_out, go ETH_HDR.
REQ-020 trans_rnet_last_in in any header state SHALL pulse udp_rerr_out and go ETH_HDR; no output produced.
REQ-021 DROP SHALL consume bytes until trans_rnet_last_in accepted, then go ETH_HDR, no error.
REQ-022 udp_rip_out and udp_rsp_out SHALL be stable from first to last payload byte of a packet and hold until the next accepted packet's UDP header completes.
REQ-023 udp_rerr_out SHALL be registered, high exactly one cycle after the causing byte's transfer.

Reset
REQ-024 On logic_rst_n low: state ETH_HDR, counters 0, mismatch flag 0, udp_rip_out 0, udp_rsp_out 0, udp_rerr_out 0, udp_rvalid_out 0, udp_rlast_out 0, trans_rnet_ready_out 1 after release.
REQ-025 Reset mid-frame SHALL abandon the frame; remaining bytes parse as a new header, mismatch, then DROP until trans_rnet_last_in.

Verification
REQ-026 Frame to LOCAL_MAC/LOCAL_IP, src 192.168.0.1:1234, UDP length 12, payload 01 02 03 04, ready held high -> 4 bytes out, last on 04, udp_rip_out C0A80001, udp_rsp_out 04D2, no error.
REQ-027 Same frame, dst port 8081 -> no udp_rvalid_out, all bytes accepted, next valid frame delivered normally.
REQ-028 UDP length 10, payload AA BB, 16 padding bytes, last on final pad -> 2 bytes out, last on BB, padding dropped, no error.
REQ-029 udp_rready_in toggled 1010... during 4-byte payload -> trans_rnet_ready_out mirrors it, no byte lost or duplicated.
REQ-030 trans_rnet_last_in at IP header byte 5 -> udp_rerr_out one-cycle pulse, no output, following frame parsed correctly.
REQ-031 logic_rst_n low for 2 cycles after 2nd payload byte -> outputs reset per REQ-024, rest of frame dropped, next frame delivered.
